systolic_array_os: RTL and testbench

Output-stationary systolic matrix-multiply array of rows×cols multiply-accumulate PEs computing C = A·W, with A rows×K and W K×cols. K is set by the number of enabled beats streamed in, one A column and one W row per beat. This is the compute core of the OS tensor datapath. All rows·cols accumulators are exposed in parallel, and the block reports completion and the run's cycle count.

---
 rtl/systolic_os_pkg.sv | 23 ++
 rtl/systolic_array_os_if.sv | 40 ++++
 rtl/pe_os.sv | 52 +++++
 rtl/systolic_array_os.sv | 189 ++++++++++++++++++
 tb/tb_systolic_array_os.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_os_pkg.sv
// Shared definitions for the output-stationary systolic array: default
// geometry, the per-beat tag carried with the A operand, and run states.
package systolic_os_pkg;

    localparam int unsigned ROWS     = 64;
    localparam int unsigned COLS     = 64;
    localparam int unsigned IP_WIDTH = 8;
    localparam int unsigned OP_WIDTH = 48;

    // Travels with each A operand so every PE knows whether to MAC and
    // whether this beat restarts its accumulator.
    typedef struct packed {
        logic valid;
        logic clr;
    } pe_tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } run_state_e;

endpackage

// File: rtl/systolic_array_os_if.sv
// Beat-stream / result bundle for systolic_array_os. The master streams
// operand beats; the slave (the array) returns accumulators and status.
interface systolic_array_os_if
    import systolic_os_pkg::*;
#(
    parameter int unsigned rows     = ROWS,
    parameter int unsigned cols     = COLS,
    parameter int unsigned ip_width = IP_WIDTH,
    parameter int unsigned op_width = OP_WIDTH
);

    logic                          en;
    logic                          clr;
    logic [rows*ip_width-1:0]      input_matrix;
    logic [cols*ip_width-1:0]      weight_matrix;
    logic                          compute_done;
    logic [31:0]                   cycles_count;
    logic [rows*cols*op_width-1:0] output_matrix;

    modport master (
        output en,
        output clr,
        output input_matrix,
        output weight_matrix,
        input  compute_done,
        input  cycles_count,
        input  output_matrix
    );

    modport slave (
        input  en,
        input  clr,
        input  input_matrix,
        input  weight_matrix,
        output compute_done,
        output cycles_count,
        output output_matrix
    );

endinterface

// File: rtl/pe_os.sv
// Output-stationary MAC cell: registers A, W and the tag through to its
// neighbours and accumulates the signed product on tagged beats only.
module pe_os
    import systolic_os_pkg::*;
#(
    parameter int unsigned ip_width = IP_WIDTH,
    parameter int unsigned op_width = OP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ip_width-1:0] a_in,
    input  logic [ip_width-1:0] w_in,
    input  pe_tag_t             tag_in,
    output logic [ip_width-1:0] a_out,
    output logic [ip_width-1:0] w_out,
    output pe_tag_t             tag_out,
    output logic [op_width-1:0] acc
);

    logic signed [2*ip_width-1:0] a_ext;
    logic signed [2*ip_width-1:0] w_ext;
    logic signed [2*ip_width-1:0] prod;
    logic        [op_width-1:0]   prod_ext;
    logic        [op_width-1:0]   acc_base;

    // Full-precision signed product, sign-extended to the accumulator width
    always_comb begin
        a_ext    = (2*ip_width)'($signed(a_in));
        w_ext    = (2*ip_width)'($signed(w_in));
        prod     = a_ext * w_ext;
        prod_ext = op_width'(prod);
        acc_base = tag_in.clr ? '0 : acc;
    end

    // Operand pass-through plus wrapping accumulate on valid beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out   <= '0;
            w_out   <= '0;
            tag_out <= '0;
            acc     <= '0;
        end else begin
            a_out   <= a_in;
            w_out   <= w_in;
            tag_out <= tag_in;
            if (tag_in.valid) begin
                acc <= acc_base + prod_ext;
            end
        end
    end

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary rows x cols systolic matmul core (C = A.W).
// Row i of A is delayed by i skew stages, column j of W by j stages, so
// beat k meets at PE(i,j) on edge k+i+j. Completion is flagged once no
// valid tag is left that could still feed a MAC.
// Optional feature macro: SYSTOLIC_OS_CYCLE_COUNT_EN enables the run
// cycle counter; without it cycles_count is tied to 0.
module systolic_array_os
    import systolic_os_pkg::*;
#(
    parameter int unsigned rows     = ROWS,
    parameter int unsigned cols     = COLS,
    parameter int unsigned ip_width = IP_WIDTH,
    parameter int unsigned op_width = OP_WIDTH
) (
    input logic                clk,
    input logic                rst,
    systolic_array_os_if.slave bus
);

    pe_tag_t in_tag;

    // clr only counts when it arrives with a valid beat
    assign in_tag = '{valid: bus.en, clr: bus.en & bus.clr};

    logic    [rows-1:0][ip_width-1:0] row_a;
    pe_tag_t [rows-1:0]               row_tag;
    logic    [rows-1:0]               row_skew_live;
    logic    [cols-1:0][ip_width-1:0] col_w;

    for (genvar i = 0; i < rows; i++) begin : g_row
        if (i == 0) begin : g_direct
            assign row_a[i]         = bus.input_matrix[i*ip_width +: ip_width];
            assign row_tag[i]       = in_tag;
            assign row_skew_live[i] = 1'b0;
        end else begin : g_skew
            logic [ip_width-1:0] a_sr   [i];
            pe_tag_t             tag_sr [i];
            logic                live;

            // i-deep delay line for row i operands and their tags
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s]   <= '0;
                        tag_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0]   <= bus.input_matrix[i*ip_width +: ip_width];
                    tag_sr[0] <= in_tag;
                    for (int s = 1; s < i; s++) begin
                        a_sr[s]   <= a_sr[s-1];
                        tag_sr[s] <= tag_sr[s-1];
                    end
                end
            end

            // Any valid tag still in this row's skew line
            always_comb begin
                live = 1'b0;
                for (int s = 0; s < i; s++) begin
                    live = live | tag_sr[s].valid;
                end
            end

            assign row_a[i]         = a_sr[i-1];
            assign row_tag[i]       = tag_sr[i-1];
            assign row_skew_live[i] = live;
        end
    end

    for (genvar j = 0; j < cols; j++) begin : g_col
        if (j == 0) begin : g_direct
            assign col_w[j] = bus.weight_matrix[j*ip_width +: ip_width];
        end else begin : g_skew
            logic [ip_width-1:0] w_sr [j];

            // j-deep delay line for column j weights
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < j; s++) begin
                        w_sr[s] <= '0;
                    end
                end else begin
                    w_sr[0] <= bus.weight_matrix[j*ip_width +: ip_width];
                    for (int s = 1; s < j; s++) begin
                        w_sr[s] <= w_sr[s-1];
                    end
                end
            end

            assign col_w[j] = w_sr[j-1];
        end
    end

    logic    [ip_width-1:0] a_grid   [rows][cols];
    logic    [ip_width-1:0] w_grid   [rows][cols];
    pe_tag_t                tag_grid [rows][cols];

    for (genvar i = 0; i < rows; i++) begin : g_pe_row
        for (genvar j = 0; j < cols; j++) begin : g_pe_col
            logic    [ip_width-1:0] a_in;
            logic    [ip_width-1:0] w_in;
            pe_tag_t                t_in;

            if (j == 0) begin : g_a_edge
                assign a_in = row_a[i];
                assign t_in = row_tag[i];
            end else begin : g_a_chain
                assign a_in = a_grid[i][j-1];
                assign t_in = tag_grid[i][j-1];
            end

            if (i == 0) begin : g_w_edge
                assign w_in = col_w[j];
            end else begin : g_w_chain
                assign w_in = w_grid[i-1][j];
            end

            pe_os #(
                .ip_width (ip_width),
                .op_width (op_width)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .a_in    (a_in),
                .w_in    (w_in),
                .tag_in  (t_in),
                .a_out   (a_grid[i][j]),
                .w_out   (w_grid[i][j]),
                .tag_out (tag_grid[i][j]),
                .acc     (bus.output_matrix[(i*cols+j)*op_width +: op_width])
            );
        end
    end

    logic pe_live;
    logic feed_live;

    // Last-column tag registers feed nothing, so they never hold up completion
    always_comb begin
        pe_live = 1'b0;
        for (int i = 0; i < int'(rows); i++) begin
            for (int j = 0; j + 1 < int'(cols); j++) begin
                pe_live = pe_live | tag_grid[i][j].valid;
            end
        end
    end

    assign feed_live = bus.en | (|row_skew_live) | pe_live;

    run_state_e state_q;
    logic       done_q;

    // Run control: a clr beat restarts, draining of all MAC work completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else if (in_tag.clr) begin
            state_q <= StBusy;
            done_q  <= 1'b0;
        end else if (state_q == StBusy && !feed_live) begin
            state_q <= StDone;
            done_q  <= 1'b1;
        end
    end

    assign bus.compute_done = done_q;

`ifdef SYSTOLIC_OS_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    // Counts from the clr beat; freezes on the edge that raises compute_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (in_tag.clr) begin
            cycles_q <= 32'd1;
        end else if (state_q == StBusy && feed_live) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign bus.cycles_count = cycles_q;
`else
    assign bus.cycles_count = '0;
`endif

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os on a 4x4 array. Expected matrices
// and cycle counts come from a software golden model pushed to a
// scoreboard when each run is streamed, and popped when compute_done rises.
module tb_systolic_array_os;

    localparam int unsigned R    = 4;
    localparam int unsigned C    = 4;
    localparam int unsigned IPW  = 8;
    localparam int unsigned OPW  = 48;
    localparam int unsigned KMAX = 128;
    localparam int unsigned NOUT = R * C * OPW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    systolic_array_os_if #(
        .rows     (R),
        .cols     (C),
        .ip_width (IPW),
        .op_width (OPW)
    ) bus ();

    systolic_array_os #(
        .rows     (R),
        .cols     (C),
        .ip_width (IPW),
        .op_width (OPW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int am [R][KMAX];
    int wm [KMAX][C];

    logic [NOUT-1:0] exp_q     [$];
    int              exp_cyc_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [NOUT-1:0] obs,
                       input logic [NOUT-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Golden C = A.W truncated to OPW bits, plus the expected cycle count
    task automatic push_expected(input int k, input int gap);
        logic [NOUT-1:0] e;
        longint          s;
        e = '0;
        for (int i = 0; i < int'(R); i++) begin
            for (int j = 0; j < int'(C); j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    s += longint'(am[i][kk]) * longint'(wm[kk][j]);
                end
                e[(i*C+j)*OPW +: OPW] = OPW'(s);
            end
        end
        exp_q.push_back(e);
`ifdef SYSTOLIC_OS_CYCLE_COUNT_EN
        exp_cyc_q.push_back(k + (k - 1) * gap + int'(R + C) - 2);
`else
        exp_cyc_q.push_back(0);
`endif
    endtask

    // Drive k beats (clr on the first) with 'gap' junk bubbles in between
    task automatic stream(input int k, input int gap);
        logic [R*IPW-1:0] a;
        logic [C*IPW-1:0] w;
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < int'(R); i++) a[i*IPW +: IPW] = IPW'(am[i][kk]);
            for (int j = 0; j < int'(C); j++) w[j*IPW +: IPW] = IPW'(wm[kk][j]);
            @(negedge clk);
            bus.en            = 1'b1;
            bus.clr           = (kk == 0);
            bus.input_matrix  = a;
            bus.weight_matrix = w;
            if (kk < k - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.en            = 1'b0;
                    bus.clr           = 1'b1;
                    bus.input_matrix  = $urandom();
                    bus.weight_matrix = $urandom();
                end
            end
        end
    endtask

    // Called right after the last beat is driven; checks done timing and result
    task automatic finish_run(input string tag);
        logic [NOUT-1:0] e;
        int              ec;
        @(negedge clk);
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        repeat (R + C - 2) @(negedge clk);
        chk({tag, " done_early"}, NOUT'(bus.compute_done), NOUT'(0));
        @(negedge clk);
        chk({tag, " done_rise"}, NOUT'(bus.compute_done), NOUT'(1));
        if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
        end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk({tag, " result"}, bus.output_matrix, e);
            chk({tag, " cycles"}, NOUT'(bus.cycles_count), NOUT'(ec));
            repeat (3) @(negedge clk);
            chk({tag, " hold_done"}, NOUT'(bus.compute_done), NOUT'(1));
            chk({tag, " hold_result"}, bus.output_matrix, e);
        end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < int'(R); i++) am[i][kk] = int'($urandom_range(255)) - 128;
            for (int j = 0; j < int'(C); j++) wm[kk][j] = int'($urandom_range(255)) - 128;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en            = 1'b0;
        bus.clr           = 1'b0;
        bus.input_matrix  = '0;
        bus.weight_matrix = '0;

        // Reset state
        #12;
        chk("reset result", bus.output_matrix, '0);
        chk("reset done", NOUT'(bus.compute_done), NOUT'(0));
        chk("reset cycles", NOUT'(bus.cycles_count), NOUT'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Identity A, W[k][j] = 4k+j+1 -> C = W
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < int'(R); i++) am[i][kk] = (i == kk) ? 1 : 0;
            for (int j = 0; j < int'(C); j++) wm[kk][j] = kk * 4 + j + 1;
        end
        push_expected(4, 0);
        stream(4, 0);
        finish_run("ident");
        chk("ident c23", NOUT'(bus.output_matrix[(2*C+3)*OPW +: OPW]), NOUT'(12));

        // Same operands with a bubble (carrying a stray clr) between beats
        push_expected(4, 1);
        stream(4, 1);
        finish_run("bubble");

        // Most-negative operands everywhere: each C = 128 * 16384
        for (int kk = 0; kk < int'(KMAX); kk++) begin
            for (int i = 0; i < int'(R); i++) am[i][kk] = -128;
            for (int j = 0; j < int'(C); j++) wm[kk][j] = -128;
        end
        push_expected(128, 0);
        stream(128, 0);
        finish_run("neg");
        chk("neg c00", NOUT'(bus.output_matrix[OPW-1:0]), NOUT'(2097152));
        chk("neg c33", NOUT'(bus.output_matrix[(3*C+3)*OPW +: OPW]), NOUT'(2097152));

        // Random signed operands
        fill_random(20);
        push_expected(20, 0);
        stream(20, 0);
        finish_run("rand");

        // Back-to-back: second clr directly follows the first run's last beat
        fill_random(6);
        stream(6, 0);
        fill_random(5);
        push_expected(5, 0);
        stream(5, 0);
        finish_run("b2b");

        // Reset mid-run, then a fresh run
        fill_random(8);
        stream(8, 0);
        #2;
        rst    = 1'b0;
        bus.en = 1'b0;
        #1;
        chk("midrst result", bus.output_matrix, '0);
        chk("midrst done", NOUT'(bus.compute_done), NOUT'(0));
        chk("midrst cycles", NOUT'(bus.cycles_count), NOUT'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fill_random(7);
        push_expected(7, 0);
        stream(7, 0);
        finish_run("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
